// File: rtl/te_uop_window.sv
// te_uop_window: buffers committed uops in a small FIFO and presents a sliding
// three-entry window (last/this/next cycle) to the downstream itype/packet stage.
// The window advances when a new source entry is available and the current
// window has been consumed (or tc is empty). drain_i pushes invalid bubbles so
// the trailing uop can reach tc. flush_i discards everything.
// Optional feature: define TE_WINDOW_BYPASS_EN to let a push into an empty FIFO
// go straight into nc when the window can advance (1-cycle instead of 2-cycle
// latency). The default build (macro undefined) routes every entry through the FIFO.

package mure_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
  } uop_entry_s;
endpackage

module te_uop_window #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  mure_pkg::uop_entry_s         uop_entry_i,
  output logic                         ready_o,
  input  logic                         ready_i,
  input  logic                         flush_i,
  input  logic                         drain_i,
  output mure_pkg::uop_entry_s         lc_uop_entry_o,
  output mure_pkg::uop_entry_s         tc_uop_entry_o,
  output mure_pkg::uop_entry_s         nc_uop_entry_o,
  output logic                         window_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  mure_pkg::uop_entry_s mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  mure_pkg::uop_entry_s lc_q, lc_d;
  mure_pkg::uop_entry_s tc_q, tc_d;
  mure_pkg::uop_entry_s nc_q, nc_d;

  logic                 fifo_empty;
  logic                 can_move;
  logic                 push;
  logic                 bypass;
  logic                 drain_src;
  logic                 shift;
  logic                 pop;
  logic                 wr_en;
  mure_pkg::uop_entry_s nc_src;

  // Acceptance depends only on the registered count, so a full FIFO never
  // accepts even if the window is about to pop an entry.
  assign ready_o = (count_q < CNT_W'(DEPTH)) && !flush_i;

  // Next-state computation for FIFO pointers, occupancy and the window.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    lc_d     = lc_q;
    tc_d     = tc_q;
    nc_d     = nc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    fifo_empty = (count_q == '0);
    can_move   = ready_i || !tc_q.valid;
    push       = uop_entry_i.valid && ready_o;
`ifdef TE_WINDOW_BYPASS_EN
    bypass     = push && fifo_empty && can_move;
`else
    bypass     = 1'b0;
`endif
    drain_src  = drain_i && fifo_empty && nc_q.valid;
    shift      = (!fifo_empty || bypass || drain_src) && can_move;
    pop        = shift && !fifo_empty;
    wr_en      = push && !bypass;

    if (!fifo_empty) begin
      nc_src = mem_q[rd_ptr_q];
    end else if (bypass) begin
      nc_src = uop_entry_i;
    end else begin
      nc_src = '0;
    end

    if (flush_i) begin
      lc_d     = '0;
      tc_d     = '0;
      nc_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (shift) begin
        lc_d = tc_q;
        tc_d = nc_q;
        nc_d = nc_src;
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  // Control and window registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lc_q     <= '0;
      tc_q     <= '0;
      nc_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lc_q     <= lc_d;
      tc_q     <= tc_d;
      nc_q     <= nc_d;
    end
  end

  // FIFO storage; written only on an accepted, non-bypassed push.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; count and pointers alone decide which slots are live.
    if (wr_en) begin
      mem_q[wr_ptr_q] <= uop_entry_i;
    end
  end

  assign lc_uop_entry_o = lc_q;
  assign tc_uop_entry_o = tc_q;
  assign nc_uop_entry_o = nc_q;
  assign window_valid_o = tc_q.valid && nc_q.valid;
  assign count_o        = count_q;

endmodule

// File: tb/tb_te_uop_window.sv
// Self-checking bench for te_uop_window: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_te_uop_window;
  import mure_pkg::*;

  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  uop_entry_s uop_entry_i;
  logic       ready_o;
  logic       ready_i;
  logic       flush_i;
  logic       drain_i;
  uop_entry_s lc_uop_entry_o;
  uop_entry_s tc_uop_entry_o;
  uop_entry_s nc_uop_entry_o;
  logic       window_valid_o;
  logic [2:0] count_o;

  te_uop_window #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .uop_entry_i    (uop_entry_i),
    .ready_o        (ready_o),
    .ready_i        (ready_i),
    .flush_i        (flush_i),
    .drain_i        (drain_i),
    .lc_uop_entry_o (lc_uop_entry_o),
    .tc_uop_entry_o (tc_uop_entry_o),
    .nc_uop_entry_o (nc_uop_entry_o),
    .window_valid_o (window_valid_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: a queue plus three window slots --------
  uop_entry_s mq[$];
  uop_entry_s m_lc, m_tc, m_nc;

  task automatic model_reset();
    mq.delete();
    m_lc = '0;
    m_tc = '0;
    m_nc = '0;
  endtask

  // Apply one clock edge of the rules to the model using the current inputs.
  task automatic model_advance();
    bit         accept;
    bit         advance_ok;
    bit         direct;
    uop_entry_s incoming;
    accept = uop_entry_i.valid && (mq.size() < DEPTH) && !flush_i;
    if (flush_i) begin
      model_reset();
    end else begin
      advance_ok = ready_i || !m_tc.valid;
`ifdef TE_WINDOW_BYPASS_EN
      direct = accept && (mq.size() == 0) && advance_ok;
`else
      direct = 1'b0;
`endif
      if (advance_ok && (mq.size() > 0 || direct || (drain_i && m_nc.valid))) begin
        if (mq.size() > 0) incoming = mq.pop_front();
        else if (direct)   incoming = uop_entry_i;
        else               incoming = '0;
        m_lc = m_tc;
        m_tc = m_nc;
        m_nc = incoming;
      end
      if (accept && !direct) mq.push_back(uop_entry_i);
    end
  endtask

  task automatic compare_model();
    check("model_count", count_o, mq.size());
    check("model_lc", lc_uop_entry_o, m_lc);
    check("model_tc", tc_uop_entry_o, m_tc);
    check("model_nc", nc_uop_entry_o, m_nc);
    check("model_window_valid", window_valid_o, m_tc.valid && m_nc.valid);
  endtask

  // One clock: check ready_o mid-cycle, advance model, compare after the edge.
  task automatic step();
    @(negedge clk_i);
    check("model_ready", ready_o, (mq.size() < DEPTH) && !flush_i);
    model_advance();
    @(posedge clk_i);
    #1;
    compare_model();
  endtask

  task automatic set_in(input logic vld, input logic [31:0] pc, input logic rdy,
                        input logic flush, input logic drain);
    uop_entry_i.valid = vld;
    uop_entry_i.pc    = pc;
    uop_entry_i.insn  = $urandom;
    ready_i           = rdy;
    flush_i           = flush;
    drain_i           = drain;
  endtask

  // Asynchronous reset asserted mid-cycle; released at a falling edge.
  task automatic do_reset();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("reset_count", count_o, 0);
    check("reset_lc", lc_uop_entry_o, 0);
    check("reset_tc", tc_uop_entry_o, 0);
    check("reset_nc", nc_uop_entry_o, 0);
    check("reset_window_valid", window_valid_o, 0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("ready_after_reset", ready_o, 1);
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic        rdy;
    logic        flush;
    logic        drain;
    logic [2:0]  cnt;
    logic [31:0] lc_pc;
    logic [31:0] tc_pc;
    logic [31:0] nc_pc;
    logic        wv;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] exp_nc[6];

    rst_ni = 1'b1;
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    model_reset();

`ifdef TE_WINDOW_BYPASS_EN
    vecs[0] = '{1, 32'h100, 1, 0, 0, 3'd0, 32'h0,   32'h0,   32'h100, 0};
    vecs[1] = '{1, 32'h104, 1, 0, 0, 3'd0, 32'h0,   32'h100, 32'h104, 1};
    vecs[2] = '{1, 32'h108, 1, 0, 0, 3'd0, 32'h100, 32'h104, 32'h108, 1};
`else
    vecs[0] = '{1, 32'h100, 1, 0, 0, 3'd1, 32'h0,   32'h0,   32'h0,   0};
    vecs[1] = '{1, 32'h104, 1, 0, 0, 3'd1, 32'h0,   32'h0,   32'h100, 0};
    vecs[2] = '{1, 32'h108, 1, 0, 0, 3'd1, 32'h0,   32'h100, 32'h104, 1};
`endif
    vecs[3] = '{0, 32'h0,   1, 0, 0, 3'd0, 32'h100, 32'h104, 32'h108, 1};
    vecs[4] = '{0, 32'h0,   1, 0, 0, 3'd0, 32'h100, 32'h104, 32'h108, 1};
    vecs[5] = '{0, 32'h0,   1, 0, 1, 3'd0, 32'h104, 32'h108, 32'h0,   0};
    vecs[6] = '{0, 32'h0,   1, 0, 1, 3'd0, 32'h104, 32'h108, 32'h0,   0};
    vecs[7] = '{0, 32'h0,   1, 0, 1, 3'd0, 32'h104, 32'h108, 32'h0,   0};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].vld, vecs[i].pc, vecs[i].rdy, vecs[i].flush, vecs[i].drain);
      step();
      check($sformatf("vec%0d_count", i), count_o, vecs[i].cnt);
      check($sformatf("vec%0d_lc_pc", i), lc_uop_entry_o.pc, vecs[i].lc_pc);
      check($sformatf("vec%0d_tc_pc", i), tc_uop_entry_o.pc, vecs[i].tc_pc);
      check($sformatf("vec%0d_nc_pc", i), nc_uop_entry_o.pc, vecs[i].nc_pc);
      check($sformatf("vec%0d_nc_valid", i), nc_uop_entry_o.valid, vecs[i].nc_pc != 0);
      check($sformatf("vec%0d_window_valid", i), window_valid_o, vecs[i].wv);
    end

    // ---------------- full FIFO with stalled window ------------------------
    do_reset();
    set_in(1'b1, 32'h10, 1'b1, 1'b0, 1'b0); step();
    set_in(1'b1, 32'h14, 1'b1, 1'b0, 1'b0); step();
    set_in(1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6 && !tc_uop_entry_o.valid; k++) step();
    check("stall_tc_valid_reached", tc_uop_entry_o.valid, 1);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h20 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step();
    end
    check("full_count", count_o, 4);
    check("full_ready", ready_o, 0);
    set_in(1'b1, 32'h30, 1'b0, 1'b0, 1'b0); step();
    check("full_fifth_ignored_count", count_o, 4);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step();
    check("release_count", count_o, 3);
    check("release_ready", ready_o, 1);
    check("release_lc_pc", lc_uop_entry_o.pc, 32'h10);
    check("release_tc_pc", tc_uop_entry_o.pc, 32'h14);
    check("release_nc_pc", nc_uop_entry_o.pc, 32'h20);

    // ---------------- push and pop together across pointer wrap ------------
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step();
    check("pp_start_count", count_o, 2);
    check("pp_start_nc_pc", nc_uop_entry_o.pc, 32'h24);
    exp_nc = '{32'h28, 32'h2C, 32'h200, 32'h204, 32'h208, 32'h20C};
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      step();
      check($sformatf("pp%0d_count", i), count_o, 2);
      check($sformatf("pp%0d_nc_pc", i), nc_uop_entry_o.pc, exp_nc[i]);
    end

    // ---------------- flush with a valid input -----------------------------
    set_in(1'b1, 32'h400, 1'b0, 1'b0, 1'b0); step();
    check("preflush_count", count_o, 3);
    set_in(1'b1, 32'h500, 1'b0, 1'b1, 1'b0);
    #1;
    check("flush_ready", ready_o, 0);
    step();
    check("flush_count", count_o, 0);
    check("flush_lc", lc_uop_entry_o, 0);
    check("flush_tc", tc_uop_entry_o, 0);
    check("flush_nc", nc_uop_entry_o, 0);
    check("flush_window_valid", window_valid_o, 0);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step();
    check("postflush_count", count_o, 0);
    check("postflush_nc_valid", nc_uop_entry_o.valid, 0);

    // ---------------- latency from push to nc ------------------------------
    set_in(1'b1, 32'h300, 1'b1, 1'b0, 1'b0); step();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
`ifdef TE_WINDOW_BYPASS_EN
    check("lat1_nc_pc", nc_uop_entry_o.pc, 32'h300);
    check("lat1_count", count_o, 0);
`else
    check("lat1_nc_valid", nc_uop_entry_o.valid, 0);
    check("lat1_count", count_o, 1);
    step();
    check("lat2_nc_pc", nc_uop_entry_o.pc, 32'h300);
    check("lat2_count", count_o, 0);
`endif

    // ---------------- randomized run against the model ---------------------
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      set_in($urandom_range(3, 0) != 0, $urandom, $urandom_range(2, 0) != 0,
             $urandom_range(39, 0) == 0, $urandom_range(5, 0) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
